// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
//   Bundles the producer request/data lines, the sync_fifo write side and
//   the arbiter status outputs into one interface.
//   Signals:
//     req          producers -> arbiter   per-requester write request
//     req_data     producers -> arbiter   flattened data, slot i at [i*DW +: DW]
//     gnt          arbiter -> producers   one-hot accept
//     fifo_full    sync_fifo -> arbiter   full flag
//     fifo_wr_en   arbiter -> sync_fifo   write enable
//     fifo_wr_data arbiter -> sync_fifo   write data
//     busy         arbiter status         high while a burst owns the port
//     owner        arbiter status         index of current/last owner
//   Modports: slave = arbiter side, master = environment side.
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               fifo_full;
    logic               fifo_wr_en;
    logic [DW-1:0]      fifo_wr_data;
    logic               busy;
    logic [PW-1:0]      owner;

    modport slave (
        input  req, req_data, fifo_full,
        output gnt, fifo_wr_en, fifo_wr_data, busy, owner
    );

    modport master (
        output req, req_data, fifo_full,
        input  gnt, fifo_wr_en, fifo_wr_data, busy, owner
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one sync_fifo write port between NREQ
//   producers. Grants are same-cycle handshakes; a winner may keep the port
//   for up to BURST_LEN consecutive beats so its burst lands contiguously.
//   Ports:
//     clk        clock, all state on rising edge
//     rst        synchronous active-high reset
//     bus        fifo_wr_arbiter_if.slave (req/req_data/gnt, fifo_full,
//                fifo_wr_en/fifo_wr_data, busy, owner)
//   Optional (macro FIFO_ARB_CNT_EN):
//     cnt_clr    clears all beat counters (wins over a same-cycle accept)
//     beat_cnt   per-requester 16-bit saturating accepted-beat counters
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef FIFO_ARB_CNT_EN
    input  logic                  cnt_clr,
    output logic [NREQ*16-1:0]    beat_cnt,
`endif
    fifo_wr_arbiter_if.slave      bus
);
    localparam int PW = $clog2(NREQ);
    localparam logic [7:0] BL8 = 8'(BURST_LEN);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] gnt;
    logic [DW-1:0]   wr_data;
    logic [PW-1:0]   sel;
    logic            any;

    // Round-robin pick: walk the scan order backwards so the last hit is
    // the first requester after ptr (ptr itself is checked last).
    always_comb begin
        sel = ptr_q;
        any = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[PW'((int'(ptr_q) + k) % NREQ)]) begin
                sel = PW'((int'(ptr_q) + k) % NREQ);
                any = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt     = '0;
        case (state_q)
            IDLE: begin
                if (!bus.fifo_full && any) begin
                    gnt[sel] = 1'b1;
                    ptr_d    = sel;
                    cnt_d    = 8'd1;
                    state_d  = (BURST_LEN > 1) ? HOLD : IDLE;
                end
            end
            HOLD: begin
                // A full FIFO freezes the burst; ownership is kept.
                if (!bus.fifo_full) begin
                    if (bus.req[ptr_q]) begin
                        gnt[ptr_q] = 1'b1;
                        cnt_d      = cnt_q + 8'd1;
                        if (cnt_d == BL8) state_d = IDLE;
                    end else begin
                        // Owner dropped out: one bubble, then re-arbitrate.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) gnt = '0;
    end

    always_comb begin
        wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) wr_data = bus.req_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt          = gnt;
    assign bus.fifo_wr_en   = |gnt;
    assign bus.fifo_wr_data = wr_data;
    assign bus.busy         = !rst && (state_q == HOLD);
    // Report the post-reset owner immediately, even before the first edge.
    assign bus.owner        = rst ? PW'(NREQ - 1) : ptr_q;

`ifdef FIFO_ARB_CNT_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        logic [15:0] bcnt_q, bcnt_d;

        always_comb begin
            bcnt_d = bcnt_q;
            if (bus.req[i] && gnt[i] && bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 16'd1;
            if (cnt_clr) bcnt_d = '0;
        end

        always_ff @(posedge clk) begin
            if (rst) bcnt_q <= '0;
            else     bcnt_q <= bcnt_d;
        end

        assign beat_cnt[i*16 +: 16] = bcnt_q;
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam logic [NREQ*DW-1:0] DFLT = {8'h40, 8'h30, 8'h20, 8'h10};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();

`ifdef FIFO_ARB_CNT_EN
    logic              cnt_clr = 1'b0;
    logic [NREQ*16-1:0] beat_cnt;
`endif

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_LEN(4)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef FIFO_ARB_CNT_EN
        .cnt_clr (cnt_clr),
        .beat_cnt(beat_cnt),
`endif
        .bus     (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] exp_q[$];   // {requester index, data}

    // 8-deep sync_fifo model; full only reported when limit_en is set.
    logic force_full = 1'b0;
    logic limit_en   = 1'b0;
    logic fifo_clr   = 1'b0;
    logic [7:0] fq[$];
    int fcount = 0;

    always @(posedge clk) begin
        if (fifo_clr) begin
            fq.delete();
            fcount <= 0;
        end else if (bus.fifo_wr_en && !bus.fifo_full) begin
            fq.push_back(bus.fifo_wr_data);
            fcount <= fcount + 1;
        end
    end

    assign bus.fifo_full = force_full | (limit_en && fcount >= 8);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted write is popped from the scoreboard.
    logic [11:0] e;
    always @(negedge clk) begin
        if (bus.fifo_wr_en) begin
            chk("gnt_onehot", $countones(bus.gnt), 1);
            chk("gnt_without_req", 32'(bus.gnt & ~bus.req), 0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got gnt=%b data=%h expected no write", bus.gnt, bus.fifo_wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("beat_gnt", 32'(bus.gnt), 32'(1) << e[11:8]);
                chk("beat_data", 32'(bus.fifo_wr_data), 32'(e[7:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input int i, input logic [7:0] d);
        exp_q.push_back({4'(i), d});
    endtask

    initial begin
        bus.req      = '0;
        bus.req_data = DFLT;

        // Reset: outputs forced low even with every request high.
        repeat (2) step();
        bus.req = '1;
        @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_wr_en", 32'(bus.fifo_wr_en), 0);
        chk("rst_wr_data", 32'(bus.fifo_wr_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_owner", 32'(bus.owner), 3);
        step();

        // All requesting: bursts of 4 rotate 0,1,2,3,0,...
        for (int b = 0; b < 32; b++) expect_beat((b / 4) % 4, 8'(8'h10 * ((b / 4) % 4 + 1)));
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k == 1) chk("s1_busy", 32'(bus.busy), 1);
            if (k == 5) chk("s1_owner", 32'(bus.owner), 1);
            step();
        end
        bus.req = '0;
        @(negedge clk);
        chk("s1_idle_gnt", 32'(bus.gnt), 0);
        chk("s1_idle_busy", 32'(bus.busy), 0);
        chk("s1_owner_end", 32'(bus.owner), 3);
`ifdef FIFO_ARB_CNT_EN
        for (int i = 0; i < NREQ; i++) chk("cnt_eight", 32'(beat_cnt[i*16 +: 16]), 8);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) chk("cnt_clr", 32'(beat_cnt[i*16 +: 16]), 0);
`endif
        step();

        // req2 alone for two beats, then a bubble, then req1.
        bus.req = 4'b0100;
        expect_beat(2, 8'h30);
        expect_beat(2, 8'h30);
        @(negedge clk);
        chk("s2_gnt_a", 32'(bus.gnt), 32'b0100);
        step();
        @(negedge clk);
        chk("s2_gnt_b", 32'(bus.gnt), 32'b0100);
        chk("s2_busy", 32'(bus.busy), 1);
        step();
        bus.req = '0;
        @(negedge clk);
        chk("s2_bubble_gnt", 32'(bus.gnt), 0);
        chk("s2_bubble_busy", 32'(bus.busy), 1);
        step();
        bus.req = 4'b0010;
        expect_beat(1, 8'h20);
        @(negedge clk);
        chk("s2_next_gnt", 32'(bus.gnt), 32'b0010);
        chk("s2_next_busy", 32'(bus.busy), 0);
        step();
        bus.req = '0;
        @(negedge clk);
        chk("s2_bubble2_gnt", 32'(bus.gnt), 0);
        step();

        // req1 burst stalled by full after 2 beats; req3 must wait.
        for (int b = 0; b < 4; b++) expect_beat(1, 8'h20);
        expect_beat(3, 8'h40);
        bus.req = 4'b0010;
        step();
        @(negedge clk);
        chk("s3_busy", 32'(bus.busy), 1);
        step();
        bus.req    = 4'b1010;
        force_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s3_full_gnt", 32'(bus.gnt), 0);
            chk("s3_full_wr_en", 32'(bus.fifo_wr_en), 0);
            chk("s3_full_busy", 32'(bus.busy), 1);
            step();
        end
        force_full = 1'b0;
        @(negedge clk);
        chk("s3_resume_a", 32'(bus.gnt), 32'b0010);
        step();
        @(negedge clk);
        chk("s3_resume_b", 32'(bus.gnt), 32'b0010);
        step();
        @(negedge clk);
        chk("s3_next_owner", 32'(bus.gnt), 32'b1000);
        step();
        bus.req = '0;
        step();

        // Fill the 8-deep FIFO from req0 with no reads.
        fifo_clr = 1'b1;
        step();
        fifo_clr = 1'b0;
        limit_en = 1'b1;
        bus.req  = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            bus.req_data[7:0] = 8'hA0 + 8'(k);
            expect_beat(0, 8'hA0 + 8'(k));
            step();
        end
        bus.req_data[7:0] = 8'hA8;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s4_full", 32'(bus.fifo_full), 1);
            chk("s4_no_wr", 32'(bus.fifo_wr_en), 0);
            step();
        end
        bus.req = '0;
        chk("s4_depth", 32'(fq.size()), 8);
        for (int k = 0; k < 8 && k < fq.size(); k++) chk("s4_readback", 32'(fq[k]), 32'(8'hA0 + 8'(k)));
        limit_en = 1'b0;
        fifo_clr = 1'b1;
        step();
        fifo_clr     = 1'b0;
        bus.req_data = DFLT;

        // Reset during the third beat of a req2 burst.
        bus.req = 4'b0100;
        expect_beat(2, 8'h30);
        expect_beat(2, 8'h30);
        @(negedge clk);
        chk("s5_gnt_a", 32'(bus.gnt), 32'b0100);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("s5_rst_gnt", 32'(bus.gnt), 0);
        chk("s5_rst_wr_en", 32'(bus.fifo_wr_en), 0);
        chk("s5_rst_data", 32'(bus.fifo_wr_data), 0);
        chk("s5_rst_busy", 32'(bus.busy), 0);
        chk("s5_rst_owner", 32'(bus.owner), 3);
        step();
        rst     = 1'b0;
        bus.req = 4'b0101;
        expect_beat(0, 8'h10);
        @(negedge clk);
        chk("s5_req0_first", 32'(bus.gnt), 32'b0001);
        step();
        bus.req = '0;
        step();

`ifdef FIFO_ARB_CNT_EN
        // Saturation: preload 16'hFFFE, three accepts leave 16'hFFFF.
        force dut.g_cnt[0].bcnt_q = 16'hFFFE;
        step();
        release dut.g_cnt[0].bcnt_q;
        bus.req = 4'b0001;
        for (int k = 0; k < 3; k++) expect_beat(0, 8'h10);
        repeat (3) step();
        bus.req = '0;
        @(negedge clk);
        chk("cnt_saturate", 32'(beat_cnt[15:0]), 32'hFFFF);
        chk("cnt_other", 32'(beat_cnt[31:16]), 0);
        step();
`endif

        repeat (2) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one sync_fifo write port (wr_en/wr_data, full) between NREQ producers.
- Grants are same-cycle handshakes. An owner may hold the port for up to BURST_LEN consecutive beats, so each producer's burst lands contiguously in the FIFO.
- Sits directly in front of sync_fifo. Drives its wr_en/wr_data and observes its full flag.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width; matches sync_fifo wr_data.
- BURST_LEN, 4, max beats per ownership (1..255). 1 gives pure per-beat round robin.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester write request; data valid while high.
- req_data  in  NREQ*DW  flattened data; requester i occupies bits [i*DW +: DW].
- gnt  out  NREQ  one-hot accept; beat i is transferred in a cycle where req[i] && gnt[i].
- fifo_full  in  1  sync_fifo full flag.
- fifo_wr_en  out  1  to sync_fifo wr_en.
- fifo_wr_data  out  DW  to sync_fifo wr_data.
- busy  out  1  high while in HOLD.
- owner  out  clog2(NREQ)  index of current/last owner.

Behaviour:
- State registers: state {IDLE, HOLD}, ptr (last owner), cnt (beats in current burst, 8 bit).
- Reset (rst high at edge): state=IDLE, ptr=NREQ-1, cnt=0. This gives requester 0 top priority after reset.
- Outputs during reset: while rst is high, gnt=0, fifo_wr_en=0, fifo_wr_data=0, busy=0, owner=NREQ-1.
- Combinational outputs:
  - gnt, fifo_wr_en and fifo_wr_data are combinational from state, req and fifo_full; zero latency.
  - fifo_wr_en = |gnt.
  - fifo_wr_data = slice of the granted requester, 0 when no grant.
  - gnt is never multi-hot. gnt[i] is never set unless req[i]=1.
- fifo_full=1: gnt=0 in any state, and state/cnt/ptr hold.
- IDLE, |req=1 and fifo_full=0:
  - Pick the first requesting index scanning ptr+1, ptr+2, ... modulo NREQ, and grant it this cycle.
  - Next: ptr<=i, cnt<=1.
  - State<=HOLD if BURST_LEN>1, else stays IDLE.
- IDLE, no req: nothing happens.
- HOLD (owner=ptr):
  - Only req[ptr] is considered; other requesters get gnt=0 even if the FIFO has space.
  - req[ptr]=1, fifo_full=0: grant, cnt<=cnt+1. If cnt+1==BURST_LEN, state<=IDLE.
  - req[ptr]=0: no grant this cycle (one bubble), state<=IDLE, cnt<=0.
  - fifo_full=1: stall. Ownership is kept and cnt is unchanged.
- After a burst the next arbitration starts at ptr+1, so no requester is granted twice in a row while others wait (for BURST_LEN=1).
- ptr wraps from NREQ-1 to 0.
- Reset mid-burst: ownership is abandoned and the partial burst is not completed. Beats already accepted stay in the FIFO.
- busy = (state==HOLD). owner = ptr.

Optional Feature:
- Macro: FIFO_ARB_CNT_EN.
- When defined, adds:
  - Input cnt_clr (1 bit).
  - Output beat_cnt (NREQ*16 bits): per-requester 16-bit saturating count of accepted beats, at [i*16 +: 16].
  - Counter i increments when req[i]&&gnt[i], saturates at 16'hFFFF.
  - Counters clear on rst or cnt_clr. If cnt_clr and an accept fall on the same cycle, clear wins.
- When undefined: no ports, no counter logic. All other behaviour is identical.

Test Plan (NREQ=4, DW=8, BURST_LEN=4, sync_fifo depth 8):
- Post-reset all req high, data i=8'h10*(i+1), fifo never full:
  - Beats 1-4 go to req0 (8'h10), then four to req1, req2, req3, then back to req0.
  - gnt stays one-hot; FIFO reads back 10,10,10,10,20,20,20,20,...
- Only req2 high, pulsed 2 cycles then low:
  - Two grants to req2, then one bubble cycle with gnt=0, busy 1->0.
  - Next req1 request is granted the cycle after.
- FIFO forced full mid-burst after 2 beats of req1:
  - gnt=0 and wr_en=0 while full; busy stays 1; req3 is not granted.
  - After full drops, req1 completes exactly 2 more beats.
- Fill the 8-deep FIFO with req0 only, no reads:
  - Exactly 8 writes accepted, full=1, no further wr_en.
  - Read-back yields the 8 values in order.
- rst asserted for 1 cycle during the 3rd beat of a req2 burst:
  - Outputs go 0 during reset.
  - Afterwards, with req0 and req2 high, req0 is granted first.
- With FIFO_ARB_CNT_EN:
  - After the first scenario runs 32 accepted beats, beat_cnt = 8 per requester.
  - cnt_clr pulse returns all counters to 0.
  - Forcing a counter to 16'hFFFE and accepting 3 beats leaves it at 16'hFFFF.
